// File: rtl/text_renderer.sv
// Character-cell text renderer: a COLS x LINES glyph-code buffer with a streaming
// writer and cursor, plus a two-stage pixel pipeline that drives an external glyph ROM.
module text_renderer #(
    parameter int COLS       = 16,
    parameter int LINES      = 2,
    parameter int HW         = 10,
    parameter int SCALE_LOG2 = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [4:0]    wr_char,
    input  logic          wr_newline,
    output logic          busy,
    input  logic          pix_valid,
    input  logic [HW-1:0] pix_x,
    input  logic [HW-1:0] pix_y,
    output logic [4:0]    rom_char,
    output logic [2:0]    rom_row,
    output logic [2:0]    rom_col,
    input  logic          rom_dot,
    output logic          pix_on_valid,
    output logic          pix_on
);

    localparam int CELLS = COLS * LINES;
    localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [4:0]    BLANK    = 5'd31;
    localparam logic [HW-1:0] COLS_HW  = HW'(COLS);
    localparam logic [HW-1:0] LINES_HW = HW'(LINES);

    typedef enum logic {ST_SWEEP, ST_IDLE} state_t;

    state_t        state, state_next;
    logic [IW-1:0] sweep_ptr, sweep_ptr_next;
    logic [CW-1:0] cur_col;
    logic [LW-1:0] cur_line;
    logic [IW-1:0] cur_idx;
    logic          wr_fire;

    logic [4:0]    mem [CELLS];
    logic          mem_we;
    logic [IW-1:0] mem_addr;
    logic [4:0]    mem_data;

    logic [HW-1:0] cell_x, cell_y;
    logic          a_valid, a_loaded, a_in_win;
    logic [IW-1:0] a_idx;
    logic [2:0]    a_row, a_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SWEEP;
            sweep_ptr <= '0;
        end else begin
            state     <= state_next;
            sweep_ptr <= sweep_ptr_next;
        end
    end

    // A clr pulse always restarts the sweep from cell 0, even mid-sweep.
    always_comb begin
        state_next     = state;
        sweep_ptr_next = sweep_ptr;
        if (clr) begin
            state_next     = ST_SWEEP;
            sweep_ptr_next = '0;
        end else if (state == ST_SWEEP) begin
            if (sweep_ptr == IW'(CELLS - 1)) begin
                state_next     = ST_IDLE;
                sweep_ptr_next = '0;
            end else begin
                sweep_ptr_next = sweep_ptr + 1'b1;
            end
        end
    end

    assign busy     = (state == ST_SWEEP);
    assign wr_ready = !busy && !clr;
    assign wr_fire  = wr_valid && wr_ready;
    assign cur_idx  = IW'(cur_line) * IW'(COLS) + IW'(cur_col);

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = sweep_ptr;
        mem_data = BLANK;
        if (state == ST_SWEEP && !clr) begin
            mem_we = 1'b1;
        end else if (wr_fire && !wr_newline) begin
            mem_we   = 1'b1;
            mem_addr = cur_idx;
            mem_data = wr_char;
        end
    end

    // The buffer has no reset; the post-reset sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_col  <= '0;
            cur_line <= '0;
        end else if (clr || busy) begin
            cur_col  <= '0;
            cur_line <= '0;
        end else if (wr_fire) begin
            if (wr_newline || cur_col == CW'(COLS - 1)) begin
                cur_col  <= '0;
                cur_line <= (cur_line == LW'(LINES - 1)) ? '0 : cur_line + 1'b1;
            end else begin
                cur_col <= cur_col + 1'b1;
            end
        end
    end

    assign cell_x = pix_x >> (3 + SCALE_LOG2);
    assign cell_y = pix_y >> (3 + SCALE_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid  <= 1'b0;
            a_loaded <= 1'b0;
            a_in_win <= 1'b0;
            a_idx    <= '0;
            a_row    <= '0;
            a_col    <= '0;
        end else begin
            a_valid <= pix_valid;
            if (pix_valid) begin
                a_loaded <= 1'b1;
                a_in_win <= (cell_x < COLS_HW) && (cell_y < LINES_HW);
                a_idx    <= IW'(cell_y) * IW'(COLS) + IW'(cell_x);
                a_row    <= 3'(pix_y >> SCALE_LOG2);
                a_col    <= 3'(pix_x >> SCALE_LOG2);
            end
        end
    end

    // Until the first pixel arrives the ROM address stays at its reset value of zero.
    always_comb begin
        rom_char = 5'd0;
        if (a_loaded) rom_char = a_in_win ? mem[a_idx] : BLANK;
    end

    assign rom_row = a_row;
    assign rom_col = a_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_on_valid <= 1'b0;
            pix_on       <= 1'b0;
        end else begin
            pix_on_valid <= a_valid;
            pix_on       <= a_valid && a_in_win && rom_dot && (rom_char != BLANK);
        end
    end

endmodule

// File: tb/tb_text_renderer.sv
// Directed bench for text_renderer: two instances (scale 1x and 2x) share one
// stimulus stream and are checked against a small buffer/ROM reference model.
module tb_text_renderer;

    logic       clk = 1'b0;
    logic       rst_n, clr, wr_valid, wr_newline, pix_valid;
    logic [4:0] wr_char;
    logic [9:0] pix_x, pix_y;

    logic       wr_ready0, busy0, rom_dot0, pix_on_valid0, pix_on0;
    logic [4:0] rom_char0;
    logic [2:0] rom_row0, rom_col0;
    logic       wr_ready1, busy1, rom_dot1, pix_on_valid1, pix_on1;
    logic [4:0] rom_char1;
    logic [2:0] rom_row1, rom_col1;

    always #5 clk = ~clk;

    text_renderer #(.COLS(16), .LINES(2), .HW(10), .SCALE_LOG2(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready0),
        .wr_char(wr_char), .wr_newline(wr_newline), .busy(busy0), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .rom_char(rom_char0), .rom_row(rom_row0),
        .rom_col(rom_col0), .rom_dot(rom_dot0), .pix_on_valid(pix_on_valid0), .pix_on(pix_on0)
    );

    text_renderer #(.COLS(16), .LINES(2), .HW(10), .SCALE_LOG2(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_valid(wr_valid), .wr_ready(wr_ready1),
        .wr_char(wr_char), .wr_newline(wr_newline), .busy(busy1), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .rom_char(rom_char1), .rom_row(rom_row1),
        .rom_col(rom_col1), .rom_dot(rom_dot1), .pix_on_valid(pix_on_valid1), .pix_on(pix_on1)
    );

    // Glyph ROM stand-in; code 31 is deliberately all-lit so BLANK gating is visible.
    function automatic logic [7:0] glyph(input logic [4:0] c, input logic [2:0] r);
        case (c)
            5'd0:    glyph = 8'h7E;
            5'd1:    glyph = (r == 3'd6) ? 8'h7C : 8'h10;
            5'd2:    glyph = 8'h00;
            5'd31:   glyph = 8'hFF;
            default: glyph = {c, r} ^ 8'hA5;
        endcase
    endfunction

    function automatic logic rom_lookup(input logic [4:0] c, input logic [2:0] r, input logic [2:0] col);
        logic [7:0] g;
        g = glyph(c, r);
        return g[3'd7 - col];
    endfunction

    assign rom_dot0 = rom_lookup(rom_char0, rom_row0, rom_col0);
    assign rom_dot1 = rom_lookup(rom_char1, rom_row1, rom_col1);

    logic [4:0] mdl_buf [32];
    int         mdl_col, mdl_line;
    int         compared, mismatched;
    logic       pend_v, pend0, pend1, pa_v, pa0, pa1, pb_v, pb0, pb1;
    logic [4:0] cap_char1;
    logic [2:0] cap_row1, cap_col1;
    logic       cap_on0, cap_on1;

    function automatic logic model_on(input int x, input int y, input int s);
        int         cx, cy;
        logic [4:0] code;
        logic [7:0] g;
        cx = x >> (3 + s);
        cy = y >> (3 + s);
        if (cx >= 16 || cy >= 2) return 1'b0;
        code = mdl_buf[cy * 16 + cx];
        if (code == 5'd31) return 1'b0;
        g = glyph(code, 3'((y >> s) & 7));
        return g[7 - ((x >> s) & 7)];
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input logic v, input int x, input int y);
        pix_valid = v;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        pend_v    = v;
        pend0     = v && model_on(x, y, 0);
        pend1     = v && model_on(x, y, 1);
    endtask

    // Every clock goes through here so the two-deep expected pipeline stays aligned.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        pb_v = pa_v; pb0 = pa0; pb1 = pa1;
        pa_v = pend_v; pa0 = pend0; pa1 = pend1;
        check_bit("pix_on_valid0", pix_on_valid0, pb_v);
        check_bit("pix_on0", pix_on0, pb0);
        check_bit("pix_on_valid1", pix_on_valid1, pb_v);
        check_bit("pix_on1", pix_on1, pb1);
    endtask

    task automatic model_write(input logic nl, input logic [4:0] c);
        if (!nl) mdl_buf[mdl_line * 16 + mdl_col] = c;
        if (nl || mdl_col == 15) begin
            mdl_col  = 0;
            mdl_line = (mdl_line + 1) % 2;
        end else begin
            mdl_col++;
        end
    endtask

    task automatic write_char(input logic [4:0] c);
        check_bit("wr_ready_before_write", wr_ready0, 1'b1);
        wr_valid = 1'b1; wr_char = c; wr_newline = 1'b0;
        apply_stimulus();
        wr_valid = 1'b0;
        model_write(1'b0, c);
    endtask

    task automatic write_newline();
        check_bit("wr_ready_before_newline", wr_ready0, 1'b1);
        wr_valid = 1'b1; wr_char = 5'd3; wr_newline = 1'b1;
        apply_stimulus();
        wr_valid = 1'b0; wr_newline = 1'b0;
        model_write(1'b1, 5'd0);
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy0 && n < budget) begin
            apply_stimulus();
            n++;
        end
        check_bit("sweep_done", busy0, 1'b0);
        for (int i = 0; i < 32; i++) mdl_buf[i] = 5'd31;
        mdl_col = 0; mdl_line = 0;
    endtask

    task automatic clear_buf();
        int n;
        clr = 1'b1;
        apply_stimulus();
        clr = 1'b0;
        wait_idle(40, n);
    endtask

    task automatic render(input int x, input int y);
        set_pix(1'b1, x, y);
        apply_stimulus();
        cap_char1 = rom_char1; cap_row1 = rom_row1; cap_col1 = rom_col1;
        set_pix(1'b0, 0, 0);
        apply_stimulus();
        cap_on0 = pix_on0; cap_on1 = pix_on1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         n, n_busy, first_zero;
        logic [9:0] seq_v, seq_on;
        logic [7:0] exp_dots;

        compared = 0; mismatched = 0;
        rst_n = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_newline = 1'b0; wr_char = 5'd0;
        pa_v = 0; pa0 = 0; pa1 = 0; pb_v = 0; pb0 = 0; pb1 = 0;
        for (int i = 0; i < 32; i++) mdl_buf[i] = 5'd31;
        mdl_col = 0; mdl_line = 0;
        set_pix(1'b0, 0, 0);

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_busy", busy0, 1'b1);
        check_bit("reset_wr_ready", wr_ready0, 1'b0);
        check_bit("reset_pix_on_valid", pix_on_valid0, 1'b0);
        check_bit("reset_pix_on", pix_on0, 1'b0);
        check_output("reset_rom_char", int'(rom_char0), 0);
        check_output("reset_rom_row", int'(rom_row0), 0);
        check_output("reset_rom_col", int'(rom_col0), 0);

        // Post-reset sweep length and wr_ready edge
        rst_n = 1'b1;
        n_busy = 0; first_zero = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy0) n_busy++;
            else if (first_zero < 0) first_zero = i;
            if (i == 31) check_bit("wr_ready_last_busy", wr_ready0, 1'b0);
            if (i == 32) begin
                check_bit("wr_ready_after_sweep", wr_ready0, 1'b1);
                check_bit("busy1_after_sweep", busy1, 1'b0);
            end
            apply_stimulus();
        end
        check_output("reset_sweep_cycles", n_busy, 32);
        check_output("reset_sweep_first_idle", first_zero, 32);

        for (int x = 0; x < 8; x++) begin
            set_pix(1'b1, x * 9, 3);
            apply_stimulus();
        end
        set_pix(1'b0, 0, 0);
        apply_stimulus();
        apply_stimulus();

        // Code 1 at (0,0), scan glyph row 6
        write_char(5'd1);
        exp_dots = 8'b0111_1100;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) set_pix(1'b1, i, 6);
            else set_pix(1'b0, 0, 0);
            apply_stimulus();
            seq_v[i]  = pix_on_valid0;
            seq_on[i] = pix_on0;
        end
        check_bit("scan_valid_head", seq_v[0], 1'b0);
        check_bit("scan_valid_tail", seq_v[9], 1'b0);
        for (int i = 1; i < 9; i++) begin
            check_bit("scan_valid", seq_v[i], 1'b1);
            check_bit("scan_dot", seq_on[i], exp_dots[8 - i]);
        end

        // Cursor wrap to line 1, newline wrap back to (0,0)
        clear_buf();
        for (int i = 0; i < 16; i++) write_char(5'd2);
        write_char(5'd1);
        render(1, 14);
        check_bit("char17_at_line1_col0", cap_on0, 1'b1);
        for (int i = 0; i < 4; i++) write_char(5'd2);
        write_newline();
        write_char(5'd1);
        render(1, 6);
        check_bit("after_newline_write_at_0", cap_on0, 1'b1);
        render(41, 14);
        check_bit("newline_writes_nothing", cap_on0, 1'b0);

        // 2x magnification instance
        clear_buf();
        write_char(5'd0);
        render(2, 2);
        check_bit("scale_dot", cap_on1, 1'b1);
        check_output("scale_rom_char", int'(cap_char1), 0);
        check_output("scale_rom_row", int'(cap_row1), 1);
        check_output("scale_rom_col", int'(cap_col1), 1);
        render(256, 2);
        check_bit("scale_outside_dot", cap_on1, 1'b0);
        check_output("scale_outside_rom_char", int'(cap_char1), 31);
        check_output("scale_outside_rom_col", int'(cap_col1), 0);

        // clr beats wr_valid; mid-sweep clr restarts the count
        clr = 1'b1; wr_valid = 1'b1; wr_char = 5'd5;
        #1;
        check_bit("clr_blocks_wr_ready", wr_ready0, 1'b0);
        apply_stimulus();
        clr = 1'b0; wr_valid = 1'b0;
        wait_idle(40, n);
        check_output("clr_sweep_cycles", n, 32);
        clr = 1'b1;
        apply_stimulus();
        clr = 1'b0;
        repeat (10) apply_stimulus();
        check_bit("mid_sweep_busy", busy0, 1'b1);
        clr = 1'b1;
        apply_stimulus();
        clr = 1'b0;
        wait_idle(50, n);
        check_output("restart_sweep_cycles", n, 32);

        // Random buffer contents and a gappy pixel stream
        for (int i = 0; i < 32; i++) write_char(5'($urandom_range(0, 31)));
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) set_pix(1'b1, $urandom_range(0, 300), $urandom_range(0, 40));
            else set_pix(1'b0, 0, 0);
            apply_stimulus();
        end

        // Asynchronous reset with valid pixels in flight
        set_pix(1'b1, 3, 3);
        apply_stimulus();
        set_pix(1'b1, 4, 3);
        apply_stimulus();
        check_bit("inflight_valid", pix_on_valid0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_bit("async_rst_valid0", pix_on_valid0, 1'b0);
        check_bit("async_rst_valid1", pix_on_valid1, 1'b0);
        check_bit("async_rst_pix_on", pix_on0, 1'b0);
        check_bit("async_rst_busy", busy0, 1'b1);
        set_pix(1'b0, 0, 0);
        pa_v = 0; pa0 = 0; pa1 = 0; pb_v = 0; pb0 = 0; pb1 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_idle(40, n);
        check_output("rst_sweep_cycles", n, 32);
        render(1, 6);
        check_bit("after_rst_blank", cap_on0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
